cp0: RTL
========

CP0 -- requirements
Module: cp0

Interface
REQ-001 SHALL have parameter PRID, default 32'h0000_4D50, value returned on reads of register 15.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port A1  input  5  mfc0 read register number.
REQ-005 SHALL have port A2  input  5  mtc0 write register number.
REQ-006 SHALL have port din  input  32  mtc0 write data.
REQ-007 SHALL have port we  input  1  mtc0 write enable.
REQ-008 SHALL have port PC  input  32  address of the M-stage victim instruction.
REQ-009 SHALL have port BD  input  1  victim instruction sits in a branch delay slot.
REQ-010 SHALL have port ExcCode  input  5 (bits 6:2)  M-stage exception code; 0 = none.
REQ-011 SHALL have port BadAddr  input  32  M-stage data address, used only with CP0_BADVADDR_EN.
REQ-012 SHALL have port HWInt  input  6 (bits 7:2)  level-sensitive hardware interrupt lines.
REQ-013 SHALL have port EXLClr  input  1  eret retiring in M stage.
REQ-014 SHALL have port IntReq  output  1  redirect to handler at 0x0000_4180 and flush pipeline.
REQ-015 SHALL have port EPC  output  32  current EPC value, for eret.
REQ-016 SHALL have port dout  output  32  mfc0 read data.

Function
REQ-017 SHALL implement SR(12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
REQ-018 SHALL implement Cause(13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
REQ-019 SHALL implement EPC(14) as 32 bits with [1:0] always 0, and PRId(15) as the PRID constant.
REQ-020 SHALL drive dout combinationally from A1; unimplemented registers read 32'h0.
REQ-021 SHALL compute int_hit = |(HWInt & IM) & IE & !EXL and exc_hit = (ExcCode != 0) & !EXL, both combinationally.
REQ-022 SHALL drive IntReq = int_hit | exc_hit in the same cycle, zero latency.
REQ-023 SHALL, on the edge after IntReq: set EXL=1; set Cause.BD=BD; set EPC = BD ? PC-4 : PC, word-aligned; set Cause.ExcCode = 0 if int_hit, else ExcCode.
REQ-024 SHALL give an interrupt priority over a simultaneous synchronous exception, recording ExcCode 0.
REQ-025 SHALL load Cause.IP from HWInt every cycle, regardless of EXL or IE.
REQ-026 SHALL, when we=1 and IntReq=0, write din into SR (IM, EXL, IE) or EPC (din[31:2]); writes to Cause, PRId or others SHALL be ignored.
REQ-027 SHALL drop the mtc0 write when IntReq=1 in the same cycle.
REQ-028 SHALL clear EXL on EXLClr=1 when IntReq=0; IntReq=1 in the same cycle wins and EXL remains 1.
REQ-029 SHALL hold EPC stable while EXL=1; nested events are masked by EXL.

Reset
REQ-030 SHALL, with reset=1 at a clock edge, set SR, Cause, EPC (and BadVAddr if present) to 0, overriding all other inputs.
REQ-031 SHALL hold IntReq at 0 from the first clock edge after reset is asserted until reset is released, because IE=0 and ExcCode is masked while reset is high.

Configuration
REQ-032 SHALL use macro CP0_BADVADDR_EN. When defined: BadVAddr(8) register, loaded from BadAddr when exc_hit and ExcCode is 4 (AdEL) or 5 (AdES), and readable via A1=8. When undefined: A1=8 reads 0 and BadAddr is unused.

Structure
REQ-033 SHALL take register numbers (8, 12, 13, 14, 15), ExcCode values (Int=0, AdEL=4, AdES=5, RI=10, Ov=12) and the handler address from the shared constants header, not local literals.
REQ-034 SHALL place the int_hit/exc_hit/IntReq logic in one combinational sub-module cp0_reqgen; all registers stay in cp0.

Verification
REQ-035 SHALL cover: reset, then IM=6'b000001, IE=1, HWInt[2]=1, PC=0x3010 -> IntReq=1 same cycle; next cycle EXL=1, EPC=0x3010, Cause.ExcCode=0.
REQ-036 SHALL cover: ExcCode=4, BD=1, PC=0x3024, BadAddr=0x7f04 -> EPC=0x3020, Cause=0x8000_0010, and BadVAddr=0x7f04 when CP0_BADVADDR_EN is defined.
REQ-037 SHALL cover: EXL=1 with HWInt and ExcCode=12 asserted -> IntReq=0 and EPC unchanged; then EXLClr -> IntReq=1 on the following cycle.
REQ-038 SHALL cover: mtc0 A2=12, din=0x0000_FC01 in the same cycle as ExcCode=10 -> SR write dropped, EXL=1, ExcCode field=10.
REQ-039 SHALL cover: mfc0 A1=15 -> PRID; A1=9 -> 0; mtc0 to Cause -> Cause unchanged.
REQ-040 SHALL cover: reset asserted mid-handler (EXL=1, EPC=0x3040) -> SR, Cause, EPC = 0 after one edge.

Source files
------------

// File: rtl/cp0_pkg.sv
// CP0 shared constants: register numbers, exception codes, handler vector.
// Imported by cp0, cp0_reqgen and the bench. Optional CP0_BADVADDR_EN.
package cp0_pkg;

   localparam logic [4:0] REG_BADVADDR = 5'd8;
   localparam logic [4:0] REG_SR       = 5'd12;
   localparam logic [4:0] REG_CAUSE    = 5'd13;
   localparam logic [4:0] REG_EPC      = 5'd14;
   localparam logic [4:0] REG_PRID     = 5'd15;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

   function automatic logic is_addr_exc(input logic [4:0] code);
      return (code == EXC_ADEL) || (code == EXC_ADES);
   endfunction

endpackage

// File: rtl/cp0_if.sv
// CP0 pipeline-side bundle: mfc0/mtc0 access, M-stage victim info, outputs.
// master = pipeline side driving CP0, slave = CP0 side.
interface cp0_if;
   import cp0_pkg::*;

   logic [4:0]  A1;
   logic [4:0]  A2;
   logic [31:0] din;
   logic        we;
   logic [31:0] PC;
   logic        BD;
   logic [6:2]  ExcCode;
   logic [31:0] BadAddr;
   logic [7:2]  HWInt;
   logic        EXLClr;
   logic        IntReq;
   logic [31:0] EPC;
   logic [31:0] dout;

   modport master (
      output A1, A2, din, we, PC, BD, ExcCode, BadAddr, HWInt, EXLClr,
      input  IntReq, EPC, dout
   );

   modport slave (
      input  A1, A2, din, we, PC, BD, ExcCode, BadAddr, HWInt, EXLClr,
      output IntReq, EPC, dout
   );

endinterface

// File: rtl/cp0_reqgen.sv
// CP0 request generator: purely combinational interrupt/exception decision.
// Ports: reset, HWInt, im, ie, exl, ExcCode -> int_hit, exc_hit, IntReq.
module cp0_reqgen
   import cp0_pkg::*;
(
   input  logic         reset,
   input  logic [7:2]   HWInt,
   input  logic [15:10] im,
   input  logic         ie,
   input  logic         exl,
   input  logic [6:2]   ExcCode,
   output logic         int_hit,
   output logic         exc_hit,
   output logic         IntReq
);

   assign int_hit = (|(HWInt & im)) & ie & ~exl;
   // reset masks the synchronous exception so IntReq stays low in reset
   assign exc_hit = (ExcCode != EXC_INT) & ~exl & ~reset;
   assign IntReq  = int_hit | exc_hit;

endmodule

// File: rtl/cp0.sv
// CP0 coprocessor: SR, Cause, EPC, PRId (+BadVAddr with CP0_BADVADDR_EN).
// Ports: clk, reset, mfc0 A1/dout, mtc0 A2/din/we, victim PC/BD/ExcCode/
// BadAddr, HWInt, EXLClr; outputs IntReq, EPC, dout.
module cp0
   import cp0_pkg::*;
#(
   parameter logic [31:0] PRID = 32'h0000_4D50
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  A1,
   input  logic [4:0]  A2,
   input  logic [31:0] din,
   input  logic        we,
   input  logic [31:0] PC,
   input  logic        BD,
   input  logic [6:2]  ExcCode,
   input  logic [31:0] BadAddr,
   input  logic [7:2]  HWInt,
   input  logic        EXLClr,
   output logic        IntReq,
   output logic [31:0] EPC,
   output logic [31:0] dout
);

   logic [15:10] im;
   logic         exl;
   logic         ie;
   logic [15:10] ip;
   logic         bd;
   logic [6:2]   exc_code;
   logic [31:2]  epc;
   logic         int_hit;
   logic         exc_hit;
   logic [31:0]  vic_pc;
   logic [31:0]  badvaddr;

   cp0_reqgen u_reqgen (
      .reset   (reset),
      .HWInt   (HWInt),
      .im      (im),
      .ie      (ie),
      .exl     (exl),
      .ExcCode (ExcCode),
      .int_hit (int_hit),
      .exc_hit (exc_hit),
      .IntReq  (IntReq)
   );

   // a delay-slot victim restarts at its branch
   assign vic_pc = BD ? (PC - 32'd4) : PC;

   always_ff @(posedge clk) begin
      if (reset) begin
         im       <= '0;
         exl      <= 1'b0;
         ie       <= 1'b0;
         ip       <= '0;
         bd       <= 1'b0;
         exc_code <= '0;
         epc      <= '0;
      end else begin
         ip <= HWInt;
         if (IntReq) begin
            exl      <= 1'b1;
            bd       <= BD;
            epc      <= vic_pc[31:2];
            exc_code <= int_hit ? EXC_INT : ExcCode;
         end else begin
            if (we && (A2 == REG_SR)) begin
               im  <= din[15:10];
               exl <= din[1];
               ie  <= din[0];
            end
            if (we && (A2 == REG_EPC) && !exl)
               epc <= din[31:2];
            if (EXLClr)
               exl <= 1'b0;
         end
      end
   end

`ifdef CP0_BADVADDR_EN
   always_ff @(posedge clk) begin
      if (reset)
         badvaddr <= '0;
      else if (exc_hit && is_addr_exc(ExcCode))
         badvaddr <= BadAddr;
   end
   logic unused_bits;
   assign unused_bits = ^vic_pc[1:0];
`else
   assign badvaddr = '0;
   logic unused_bits;
   assign unused_bits = ^{vic_pc[1:0], BadAddr};
`endif

   assign EPC = {epc, 2'b00};

   always_comb begin
      dout = '0;
      case (A1)
         REG_SR:       dout = {16'b0, im, 8'b0, exl, ie};
         REG_CAUSE:    dout = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};
         REG_EPC:      dout = {epc, 2'b00};
         REG_PRID:     dout = PRID;
         REG_BADVADDR: dout = badvaddr;
         default:      dout = '0;
      endcase
   end

endmodule
